// File: rtl/float64_mul_core.sv
`default_nettype none
// ============================================================================
// Module   : float64_mul_core
// Brief    : binary64 multiply front end (unpack, specials, radix-4 product).
//            Define FMUL_SUBNORM_EN to normalize subnormals (else flush-to-zero).
// Revision : 1.0
// ============================================================================
module float64_mul_core #(
    parameter int MUL_RADIX_BITS = 2
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        ap_start,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic [31:0] float_exception_flag_i,
    output logic [31:0] float_exception_flag_o,
    output logic        float_exception_flag_o_ap_vld,
    output logic        bypass,
    output logic [63:0] z_bypass,
    output logic        zSign,
    output logic [12:0] zExp,
    output logic [63:0] zSig
);

    localparam logic [4:0]  c_MUL_LAST = 5'(54 / MUL_RADIX_BITS - 1);
    localparam logic [31:0] c_FLAG_INVALID = 32'h0000_0010;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_NORM = 3'd1,
        S_MUL  = 3'd2,
        S_ADJ  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t         state_q;
    logic [62:0]    a_q, b_q;
    logic           sign_q;
    logic [107:0]   a_sh_q, acc_q;
    logic [53:0]    b_sh_q;
    logic [12:0]    exp_q;
    logic [4:0]     cnt_q;
    logic           done_q, vld_q, bypass_q, zsign_q;
    logic [31:0]    flags_q;
    logic [63:0]    zbyp_q, zsig_q;
    logic [12:0]    zexp_q;

    // Returns {exp[12:0], sig[52:0]} for a non-special operand.
    function automatic logic [65:0] unpack_op(input logic [62:0] op);
        logic [12:0] e;
        logic [52:0] s;
`ifdef FMUL_SUBNORM_EN
        logic [5:0]  sh;
        if (op[62:52] == 11'd0) begin
            sh = 6'd0;
            for (int i = 0; i < 52; i++) begin
                if (op[i]) sh = 6'(52 - i);
            end
            s = {1'b0, op[51:0]} << sh;
            e = 13'd1 - {7'd0, sh};
        end else begin
            s = {1'b1, op[51:0]};
            e = {2'b00, op[62:52]};
        end
`else
        s = {1'b1, op[51:0]};
        e = {2'b00, op[62:52]};
`endif
        return {e, s};
    endfunction

    // Operand classification on the live inputs (used only in IDLE)
    logic w_a_nan, w_b_nan, w_a_snan, w_b_snan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
    logic w_sign, w_special_d, w_invalid_d;
    logic [63:0] w_zbyp_d;

    always_comb begin
        w_a_nan  = (&a[62:52]) && (|a[51:0]);
        w_b_nan  = (&b[62:52]) && (|b[51:0]);
        w_a_snan = w_a_nan && !a[51];
        w_b_snan = w_b_nan && !b[51];
        w_a_inf  = (&a[62:52]) && !(|a[51:0]);
        w_b_inf  = (&b[62:52]) && !(|b[51:0]);
`ifdef FMUL_SUBNORM_EN
        w_a_zero = (a[62:52] == 11'd0) && !(|a[51:0]);
        w_b_zero = (b[62:52] == 11'd0) && !(|b[51:0]);
`else
        w_a_zero = (a[62:52] == 11'd0);
        w_b_zero = (b[62:52] == 11'd0);
`endif
        w_sign      = a[63] ^ b[63];
        w_special_d = 1'b1;
        w_invalid_d = 1'b0;
        w_zbyp_d    = 64'd0;
        if (w_a_nan || w_b_nan) begin
            w_zbyp_d    = (w_b_nan ? b : a) | 64'h0008_0000_0000_0000;
            w_invalid_d = w_a_snan || w_b_snan;
        end else if ((w_a_inf && w_b_zero) || (w_b_inf && w_a_zero)) begin
            w_zbyp_d    = 64'h7FFF_FFFF_FFFF_FFFF;
            w_invalid_d = 1'b1;
        end else if (w_a_inf || w_b_inf) begin
            w_zbyp_d = {w_sign, 11'h7FF, 52'd0};
        end else if (w_a_zero || w_b_zero) begin
            w_zbyp_d = {w_sign, 63'd0};
        end else begin
            w_special_d = 1'b0;
        end
    end

    logic [65:0]  w_a_unp, w_b_unp;
    logic [12:0]  w_exp_d;
    logic [107:0] w_pp_d;
    logic [63:0]  w_zsig_pre, w_zsig_d;
    logic [12:0]  w_zexp_d;
    logic         unused_acc;

    always_comb begin
        w_a_unp = unpack_op(a_q);
        w_b_unp = unpack_op(b_q);
        w_exp_d = w_a_unp[65:53] + w_b_unp[65:53] - 13'h3FF;

        case (b_sh_q[1:0])
            2'd0:    w_pp_d = 108'd0;
            2'd1:    w_pp_d = a_sh_q;
            2'd2:    w_pp_d = a_sh_q << 1;
            default: w_pp_d = a_sh_q + (a_sh_q << 1);
        endcase

        // Align as the top word of (aSig<<10)*(bSig<<11): leading one at bit 62 or 61.
        w_zsig_pre = {1'b0, acc_q[105:43]} | {63'd0, |acc_q[42:0]};
        w_zsig_d   = w_zsig_pre;
        w_zexp_d   = exp_q;
        if (!w_zsig_pre[62]) begin
            w_zsig_d = w_zsig_pre << 1;
            w_zexp_d = exp_q - 13'd1;
        end
        unused_acc = ^acc_q[107:106];
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q  <= S_IDLE;
            a_q      <= 63'd0;
            b_q      <= 63'd0;
            sign_q   <= 1'b0;
            a_sh_q   <= 108'd0;
            b_sh_q   <= 54'd0;
            acc_q    <= 108'd0;
            exp_q    <= 13'd0;
            cnt_q    <= 5'd0;
            done_q   <= 1'b0;
            vld_q    <= 1'b0;
            bypass_q <= 1'b0;
            zbyp_q   <= 64'd0;
            zsign_q  <= 1'b0;
            zexp_q   <= 13'd0;
            zsig_q   <= 64'd0;
            flags_q  <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ap_start) begin
                        a_q    <= a[62:0];
                        b_q    <= b[62:0];
                        sign_q <= w_sign;
                        if (w_special_d) begin
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            bypass_q <= 1'b1;
                            zbyp_q   <= w_zbyp_d;
                            zsign_q  <= w_sign;
                            zexp_q   <= 13'd0;
                            zsig_q   <= 64'd0;
                            vld_q    <= w_invalid_d;
                            flags_q  <= float_exception_flag_i |
                                        (w_invalid_d ? c_FLAG_INVALID : 32'd0);
                        end else begin
                            state_q <= S_NORM;
                        end
                    end
                end
                S_NORM: begin
                    a_sh_q  <= {55'd0, w_a_unp[52:0]};
                    b_sh_q  <= {1'b0, w_b_unp[52:0]};
                    exp_q   <= w_exp_d;
                    acc_q   <= 108'd0;
                    cnt_q   <= 5'd0;
                    state_q <= S_MUL;
                end
                S_MUL: begin
                    acc_q  <= acc_q + w_pp_d;
                    a_sh_q <= a_sh_q << MUL_RADIX_BITS;
                    b_sh_q <= b_sh_q >> MUL_RADIX_BITS;
                    cnt_q  <= cnt_q + 5'd1;
                    if (cnt_q == c_MUL_LAST) state_q <= S_ADJ;
                end
                S_ADJ: begin
                    state_q  <= S_DONE;
                    done_q   <= 1'b1;
                    bypass_q <= 1'b0;
                    zsign_q  <= sign_q;
                    zexp_q   <= w_zexp_d;
                    zsig_q   <= w_zsig_d;
                    vld_q    <= 1'b0;
                    flags_q  <= float_exception_flag_i;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                    vld_q   <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ap_done                       = done_q;
    assign ap_ready                      = done_q;
    assign ap_idle                       = (state_q == S_IDLE) && !ap_start;
    assign float_exception_flag_o        = flags_q;
    assign float_exception_flag_o_ap_vld = vld_q;
    assign bypass                        = bypass_q;
    assign z_bypass                      = zbyp_q;
    assign zSign                         = zsign_q;
    assign zExp                          = zexp_q;
    assign zSig                          = zsig_q;

endmodule
`default_nettype wire

// File: tb/tb_float64_mul_core.sv
`default_nettype none
// Bench for float64_mul_core: vector table with a scoreboard queue plus
// hand-written start-ignore, back-to-back and reset sequences.
module tb_float64_mul_core;

    logic        ap_clk = 1'b0;
    logic        ap_rst, ap_start;
    logic        ap_done, ap_idle, ap_ready;
    logic [63:0] a, b;
    logic [31:0] flags_i, flags_o;
    logic        vld, bypass_o, zsign_o;
    logic [63:0] zbyp_o, zsig_o;
    logic [12:0] zexp_o;

    float64_mul_core #(.MUL_RADIX_BITS(2)) dut (
        .ap_clk                        (ap_clk),
        .ap_rst                        (ap_rst),
        .ap_start                      (ap_start),
        .ap_done                       (ap_done),
        .ap_idle                       (ap_idle),
        .ap_ready                      (ap_ready),
        .a                             (a),
        .b                             (b),
        .float_exception_flag_i        (flags_i),
        .float_exception_flag_o        (flags_o),
        .float_exception_flag_o_ap_vld (vld),
        .bypass                        (bypass_o),
        .z_bypass                      (zbyp_o),
        .zSign                         (zsign_o),
        .zExp                          (zexp_o),
        .zSig                          (zsig_o)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [63:0] a, b;
        logic [31:0] fi;
        logic        byp;
        logic [63:0] zb;
        logic        sgn;
        logic [12:0] ze;
        logic [63:0] zs;
        logic [31:0] fo;
        logic        vld;
        int          lat;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic void add_num(input logic [63:0] va, vb, input logic [31:0] fi,
                                    input logic s, input logic [12:0] e, input logic [63:0] z);
        vec_t v;
        v.a = va; v.b = vb; v.fi = fi; v.byp = 1'b0; v.zb = 64'd0;
        v.sgn = s; v.ze = e; v.zs = z; v.fo = fi; v.vld = 1'b0; v.lat = 30;
        vecs.push_back(v);
    endfunction

    function automatic void add_spc(input logic [63:0] va, vb, input logic [31:0] fi,
                                    input logic [63:0] zb, input logic inv);
        vec_t v;
        v.a = va; v.b = vb; v.fi = fi; v.byp = 1'b1; v.zb = zb;
        v.sgn = 1'b0; v.ze = 13'd0; v.zs = 64'd0;
        v.fo = fi | (inv ? 32'h10 : 32'h0); v.vld = inv; v.lat = 1;
        vecs.push_back(v);
    endfunction

    task automatic run(input vec_t v, input bit noise);
        vec_t e;
        int   n;
        bit   got;
        @(negedge ap_clk);
        a = v.a; b = v.b; flags_i = v.fi; ap_start = 1'b1;
        sb.push_back(v);
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        n = 1;
        got = ap_done;
        while (!got && n < 40) begin
            if (noise && n == 3) begin
                a = {$urandom, $urandom};
                b = {$urandom, $urandom};
                ap_start = 1'b1;
            end
            @(posedge ap_clk); #1;
            n++;
            got = ap_done;
        end
        ap_start = 1'b0;
        e = sb.pop_front();
        check("done_seen", 64'(got), 64'd1);
        check("latency", 64'(n), 64'(e.lat));
        check("ready_eq_done", 64'(ap_ready), 64'(ap_done));
        check("bypass", 64'(bypass_o), 64'(e.byp));
        if (e.byp) begin
            check("z_bypass", zbyp_o, e.zb);
        end else begin
            check("zSign", 64'(zsign_o), 64'(e.sgn));
            check("zExp", 64'(zexp_o), 64'(e.ze));
            check("zSig", zsig_o, e.zs);
        end
        check("flags_o", 64'(flags_o), 64'(e.fo));
        check("flags_vld", 64'(vld), 64'(e.vld));
        @(posedge ap_clk); #1;
        check("done_pulse_end", 64'(ap_done), 64'd0);
        check("idle_after", 64'(ap_idle), 64'd1);
    endtask

    initial begin
        bit seen;
        ap_rst = 1'b1; ap_start = 1'b0; a = 64'd0; b = 64'd0; flags_i = 32'd0;

        add_num(64'h3FF0000000000000, 64'h3FF0000000000000, 32'h5, 1'b0, 13'h3FE, 64'h4000000000000000);
        add_num(64'h3FF8000000000000, 64'hBFF8000000000000, 32'h0, 1'b1, 13'h3FF, 64'h4800000000000000);
        add_spc(64'h7FF0000000000000, 64'h0000000000000000, 32'h0, 64'h7FFFFFFFFFFFFFFF, 1'b1);
        add_spc(64'h7FF0000000000001, 64'h3FF0000000000000, 32'h0, 64'h7FF8000000000001, 1'b1);
`ifdef FMUL_SUBNORM_EN
        add_num(64'h0000000000000001, 64'h4330000000000000, 32'h0, 1'b0, 13'h000, 64'h4000000000000000);
`else
        add_spc(64'h0000000000000001, 64'h4330000000000000, 32'h0, 64'h0000000000000000, 1'b0);
`endif
        add_spc(64'h3FF0000000000000, 64'hFFF8000000000000, 32'h1, 64'hFFF8000000000000, 1'b0);
        add_spc(64'h7FF0000000000000, 64'hC000000000000000, 32'h0, 64'hFFF0000000000000, 1'b0);
        add_spc(64'h8000000000000000, 64'h4008000000000000, 32'h0, 64'h8000000000000000, 1'b0);
        add_spc(64'h7FF0000000000000, 64'h7FF4000000000000, 32'h4, 64'h7FFC000000000000, 1'b1);
        add_num(64'h4000000000000000, 64'h4008000000000000, 32'h0, 1'b0, 13'h400, 64'h6000000000000000);
        add_num(64'h3FF0000000000001, 64'h3FF0000000000001, 32'h0, 1'b0, 13'h3FE, 64'h4000000000000802);
        add_num(64'h3FFFFFFFFFFFFFFF, 64'h3FFFFFFFFFFFFFFF, 32'h8, 1'b0, 13'h3FF, 64'h7FFFFFFFFFFFF801);
        add_num(64'h0010000000000000, 64'h0010000000000000, 32'h0, 1'b0, 13'h1C02, 64'h4000000000000000);

        repeat (3) @(posedge ap_clk);
        #1;
        ap_rst = 1'b0;
        check("rst_done", 64'(ap_done), 64'd0);
        check("rst_ready", 64'(ap_ready), 64'd0);
        check("rst_idle", 64'(ap_idle), 64'd1);
        check("rst_bypass", 64'(bypass_o), 64'd0);
        check("rst_z_bypass", zbyp_o, 64'd0);
        check("rst_zSign", 64'(zsign_o), 64'd0);
        check("rst_zExp", 64'(zexp_o), 64'd0);
        check("rst_zSig", zsig_o, 64'd0);
        check("rst_vld", 64'(vld), 64'd0);

        foreach (vecs[i]) run(vecs[i], 1'b0);

        // Start pulses and operand changes mid-multiply must be ignored
        run(vecs[1], 1'b1);

        // Back-to-back specials with start held high
        @(negedge ap_clk);
        a = 64'h7FF0000000000000; b = 64'd0; flags_i = 32'd0; ap_start = 1'b1;
        @(posedge ap_clk); #1;
        check("b2b_done1", 64'(ap_done), 64'd1);
        @(posedge ap_clk); #1;
        check("b2b_gap_done", 64'(ap_done), 64'd0);
        check("b2b_gap_idle", 64'(ap_idle), 64'd0);
        @(posedge ap_clk); #1;
        check("b2b_done2", 64'(ap_done), 64'd1);
        check("b2b_z_bypass", zbyp_o, 64'h7FFFFFFFFFFFFFFF);
        ap_start = 1'b0;
        @(posedge ap_clk); #1;

        // Reset at cycle 10 of a multiply, after a result with nonzero zSig
        run(vecs[1], 1'b0);
        @(negedge ap_clk);
        a = 64'h3FF0000000000000; b = 64'h3FF0000000000000; ap_start = 1'b1;
        @(posedge ap_clk); #1;
        ap_start = 1'b0;
        repeat (9) @(posedge ap_clk);
        #1;
        ap_rst = 1'b1;
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        check("rstmid_idle", 64'(ap_idle), 64'd1);
        check("rstmid_zSig", zsig_o, 64'd0);
        check("rstmid_zExp", 64'(zexp_o), 64'd0);
        check("rstmid_done", 64'(ap_done), 64'd0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge ap_clk); #1;
            if (ap_done) seen = 1'b1;
        end
        check("rstmid_no_done", 64'(seen), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
